// File: rtl/adc_capture_pkg.sv
// Shared width defaults and state encoding for the ADC capture controller.
package adc_capture_pkg;
    localparam int DATA_W  = 12;
    localparam int CNT_W   = 20;
    localparam int BLANK_W = 16;
    localparam int DECIM_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BLANK   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;
endpackage

// File: rtl/adc_decimator.sv
// Keep-1-of-N decimator: the phase advances on each valid sample, and a sample is kept at phase 0.
module adc_decimator #(
    parameter int DECIM_W = adc_capture_pkg::DECIM_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               valid,
    input  logic [DECIM_W-1:0] decim,
    output logic               keep
);
    logic [DECIM_W-1:0] phase;
    logic               last;

    assign keep = valid && (phase == '0);
    // A factor of 0 or 1 pins the phase at 0, so every valid sample is kept.
    assign last = (decim <= DECIM_W'(1)) || (phase == decim - 1'b1);

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
        end else if (clear) begin
            phase <= '0;
        end else if (valid) begin
            phase <= last ? '0 : phase + 1'b1;
        end
    end
endmodule

// File: rtl/adc_capture_ctrl.sv
// Start-triggered ADC capture: blanking, decimation, and FIFO writes that preserve the time base.
module adc_capture_ctrl #(
    parameter int DATA_W  = adc_capture_pkg::DATA_W,
    parameter int CNT_W   = adc_capture_pkg::CNT_W,
    parameter int BLANK_W = adc_capture_pkg::BLANK_W,
    parameter int DECIM_W = adc_capture_pkg::DECIM_W
) (
    input  logic               clk_50M,
    input  logic               rst_n,
    input  logic               sys_start_pulse,
    input  logic               abort,
    input  logic [DATA_W-1:0]  adc_data,
    input  logic               adc_valid,
    input  logic [BLANK_W-1:0] cfg_blank_cycles,
    input  logic [CNT_W-1:0]   cfg_sample_count,
    input  logic [DECIM_W-1:0] cfg_decim,
    output logic [DATA_W-1:0]  fifo_data,
    output logic               fifo_wrreq,
    input  logic               fifo_wrfull,
    output logic               capture_busy,
    output logic               capture_done,
    output logic               overflow_flag,
    output logic [CNT_W-1:0]   drop_count,
    output logic [CNT_W-1:0]   samples_written
);
    import adc_capture_pkg::*;

    state_t             state, state_next;
    logic [BLANK_W-1:0] blank_left;
    logic [CNT_W-1:0]   count_l;
    logic [CNT_W-1:0]   slot_idx;
    logic [DECIM_W-1:0] decim_l;
    logic               start_ok;
    logic               keep;
    logic               last_slot;

    assign start_ok  = (state == IDLE) && sys_start_pulse && !abort;
    assign last_slot = (slot_idx + 1'b1) == count_l;

    adc_decimator #(.DECIM_W(DECIM_W)) u_decim (
        .clk   (clk_50M),
        .rst_n (rst_n),
        .clear (start_ok),
        .valid (adc_valid && (state == CAPTURE) && !abort),
        .decim (decim_l),
        .keep  (keep)
    );

    // NOTE: state_next gets a default before the case so no path can infer a latch.
    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (sys_start_pulse) begin
                        if (cfg_blank_cycles != '0)
                            state_next = BLANK;
                        else
                            state_next = (cfg_sample_count == '0) ? DONE : CAPTURE;
                    end
                end
                BLANK: begin
                    if (blank_left == BLANK_W'(1))
                        state_next = (count_l == '0) ? DONE : CAPTURE;
                end
                CAPTURE: begin
                    if (keep && last_slot)
                        state_next = DONE;
                end
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            capture_busy <= 1'b0;
            capture_done <= 1'b0;
            fifo_wrreq   <= 1'b0;
        end else begin
            state        <= state_next;
            capture_busy <= (state_next == BLANK) || (state_next == CAPTURE);
            capture_done <= (state == DONE) && !abort;
            fifo_wrreq   <= keep && !fifo_wrfull;
        end
    end

    // A dropped slot still advances slot_idx so sample n always maps to the same time index.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            blank_left      <= '0;
            count_l         <= '0;
            decim_l         <= '0;
            slot_idx        <= '0;
            fifo_data       <= '0;
            overflow_flag   <= 1'b0;
            drop_count      <= '0;
            samples_written <= '0;
        end else if (start_ok) begin
            blank_left      <= cfg_blank_cycles;
            count_l         <= cfg_sample_count;
            decim_l         <= (cfg_decim == '0) ? DECIM_W'(1) : cfg_decim;
            slot_idx        <= '0;
            overflow_flag   <= 1'b0;
            drop_count      <= '0;
            samples_written <= '0;
        end else if ((state == BLANK) && !abort) begin
            blank_left <= blank_left - 1'b1;
        end else if (keep) begin
            slot_idx <= slot_idx + 1'b1;
            if (fifo_wrfull) begin
                overflow_flag <= 1'b1;
                drop_count    <= (drop_count == '1) ? drop_count : drop_count + 1'b1;
            end else begin
                fifo_data       <= adc_data;
                samples_written <= samples_written + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Randomized directed bench for adc_capture_ctrl against a per-edge reference model of one shot.
module tb_adc_capture_ctrl;
    localparam int DATA_W  = 12;
    localparam int CNT_W   = 20;
    localparam int BLANK_W = 16;
    localparam int DECIM_W = 4;

    logic               clk_50M = 1'b0;
    logic               rst_n = 1'b0;
    logic               sys_start_pulse = 1'b0;
    logic               abort = 1'b0;
    logic [DATA_W-1:0]  adc_data = '0;
    logic               adc_valid = 1'b0;
    logic [BLANK_W-1:0] cfg_blank_cycles = '0;
    logic [CNT_W-1:0]   cfg_sample_count = '0;
    logic [DECIM_W-1:0] cfg_decim = '0;
    logic [DATA_W-1:0]  fifo_data;
    logic               fifo_wrreq;
    logic               fifo_wrfull = 1'b0;
    logic               capture_busy;
    logic               capture_done;
    logic               overflow_flag;
    logic [CNT_W-1:0]   drop_count;
    logic [CNT_W-1:0]   samples_written;

    adc_capture_ctrl dut (
        .clk_50M          (clk_50M),
        .rst_n            (rst_n),
        .sys_start_pulse  (sys_start_pulse),
        .abort            (abort),
        .adc_data         (adc_data),
        .adc_valid        (adc_valid),
        .cfg_blank_cycles (cfg_blank_cycles),
        .cfg_sample_count (cfg_sample_count),
        .cfg_decim        (cfg_decim),
        .fifo_data        (fifo_data),
        .fifo_wrreq       (fifo_wrreq),
        .fifo_wrfull      (fifo_wrfull),
        .capture_busy     (capture_busy),
        .capture_done     (capture_done),
        .overflow_flag    (overflow_flag),
        .drop_count       (drop_count),
        .samples_written  (samples_written)
    );

    always #10 clk_50M = ~clk_50M;

    int cyc = 0;
    always @(posedge clk_50M) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Monitor: writes and done pulses, stamped as edge offsets from the start edge.
    int              e0 = 0;
    bit              mon_en = 0;
    int              obs_off[$];
    logic [DATA_W-1:0] obs_dat[$];
    int              done_off[$];

    always @(negedge clk_50M) begin
        if (mon_en) begin
            if (fifo_wrreq === 1'b1) begin
                obs_off.push_back(cyc - e0);
                obs_dat.push_back(fifo_data);
            end
            if (capture_done === 1'b1) done_off.push_back(cyc - e0);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One shot: build stimulus per edge offset, predict writes from the rules, drive, compare.
    task automatic run_shot(input string name, input int blank, input int count, input int decim,
                            input int vprob, input int fprob, input int full_lo, input int full_hi,
                            input int abort_edge, input int restart_edge, input bit ramp);
        bit                v_a[$], f_a[$], s_a[$], ab_a[$];
        logic [DATA_W-1:0] d_a[$];
        int                exp_off[$];
        logic [DATA_W-1:0] exp_dat[$];
        int                dd, slots, vidx, dropped, e_last, bad;
        bit                fin, aborted, v, f;
        logic [DATA_W-1:0] dat;

        dd      = (decim == 0) ? 1 : decim;
        slots   = 0;
        vidx    = 0;
        dropped = 0;
        aborted = 0;
        fin     = (count == 0);
        e_last  = blank;
        for (int e = 0; e < 60000; e++) begin
            v   = ($urandom_range(99) < vprob);
            dat = ramp ? DATA_W'(vidx) : DATA_W'($urandom);
            f   = ((e >= full_lo) && (e <= full_hi)) || ($urandom_range(99) < fprob);
            if (!fin && (e > blank)) begin
                if (e == abort_edge) begin
                    fin = 1; aborted = 1; e_last = e;
                end else if (v) begin
                    if ((vidx % dd) == 0) begin
                        slots++;
                        if (f) dropped++;
                        else begin
                            exp_off.push_back(e);
                            exp_dat.push_back(dat);
                        end
                        if (slots == count) begin
                            fin = 1; e_last = e;
                        end
                    end
                    vidx++;
                end
            end
            v_a.push_back(v);
            d_a.push_back(dat);
            f_a.push_back(f);
            s_a.push_back((e == 0) || (e == restart_edge));
            ab_a.push_back(e == abort_edge);
            if (fin && (e >= e_last + 4)) break;
        end

        for (int i = 0; i < v_a.size(); i++) begin
            @(posedge clk_50M);
            #1;
            if (i == 0) begin
                e0 = cyc + 1;
                obs_off.delete();
                obs_dat.delete();
                done_off.delete();
                mon_en = 1;
                cfg_blank_cycles = BLANK_W'(blank);
                cfg_sample_count = CNT_W'(count);
                cfg_decim        = DECIM_W'(decim);
            end else if (i == 1) begin
                cfg_blank_cycles = BLANK_W'($urandom);
                cfg_sample_count = CNT_W'($urandom);
                cfg_decim        = DECIM_W'($urandom);
            end
            sys_start_pulse = s_a[i];
            abort           = ab_a[i];
            adc_valid       = v_a[i];
            adc_data        = d_a[i];
            fifo_wrfull     = f_a[i];
        end
        @(posedge clk_50M);
        #1;
        sys_start_pulse = 0;
        abort           = 0;
        adc_valid       = 0;
        fifo_wrfull     = 0;
        @(negedge clk_50M);
        mon_en = 0;

        check({name, ".nwr"}, obs_off.size(), exp_off.size());
        bad = 0;
        for (int k = 0; k < obs_off.size() && k < exp_off.size(); k++)
            if ((obs_off[k] != exp_off[k]) || (obs_dat[k] !== exp_dat[k])) bad++;
        check({name, ".wr_seq_bad"}, bad, 0);
        check({name, ".done_n"}, done_off.size(), aborted ? 0 : 1);
        if (done_off.size() > 0) check({name, ".done_at"}, done_off[0], e_last + 1);
        check({name, ".written"}, samples_written, exp_off.size());
        check({name, ".drops"}, drop_count, dropped);
        check({name, ".ovf"}, overflow_flag, dropped > 0);
        check({name, ".busy"}, capture_busy, 0);
    endtask

    initial begin
        #5;
        check("rst.wrreq", fifo_wrreq, 0);
        check("rst.data", fifo_data, 0);
        check("rst.busy", capture_busy, 0);
        check("rst.done", capture_done, 0);
        check("rst.ovf", overflow_flag, 0);
        check("rst.drop", drop_count, 0);
        check("rst.written", samples_written, 0);
        #30 rst_n = 1;
        repeat (2) @(posedge clk_50M);

        run_shot("t1", 10, 8, 1, 100, 0, -1, -2, -1, -1, 1);
        check("t1.first_wr_at", (obs_off.size() > 0) ? obs_off[0] : -1, 11);
        run_shot("t2", 5, 10000, 2, 100, 0, -1, -2, -1, -1, 1);
        run_shot("t3_dec0", 10, 8, 0, 100, 0, -1, -2, -1, -1, 1);
        run_shot("t4_full", 10, 16, 1, 100, 0, 16, 18, -1, -1, 1);
        check("t4.drop3", drop_count, 3);
        check("t4.written13", samples_written, 13);
        run_shot("t4_nofull", 10, 16, 1, 100, 0, -1, -2, -1, -1, 1);
        run_shot("t5_abort", 10, 16, 1, 100, 0, -1, -2, 15, -1, 1);
        check("t5.written4", samples_written, 4);
        run_shot("t5_after", 3, 5, 3, 60, 0, -1, -2, -1, -1, 0);
        run_shot("t6_cnt0", 7, 0, 1, 100, 0, -1, -2, -1, -1, 0);
        run_shot("t7_restart", 10, 8, 1, 100, 0, -1, -2, -1, 3, 1);
        for (int r = 0; r < 8; r++)
            run_shot($sformatf("rnd%0d", r), $urandom_range(20), $urandom_range(30),
                     $urandom_range(5), 30 + $urandom_range(70), $urandom_range(40),
                     -1, -2, -1, -1, $urandom_range(1));

        // Asynchronous reset in the middle of a capture.
        @(posedge clk_50M);
        #1;
        cfg_blank_cycles = 2;
        cfg_sample_count = 50;
        cfg_decim        = 1;
        sys_start_pulse  = 1;
        @(posedge clk_50M);
        #1;
        sys_start_pulse = 0;
        adc_valid       = 1;
        adc_data        = 12'hABC;
        repeat (8) @(posedge clk_50M);
        #1;
        check("arst.busy_before", capture_busy, 1);
        check("arst.wrreq_before", fifo_wrreq, 1);
        #3 rst_n = 0;
        #1;
        check("arst.wrreq", fifo_wrreq, 0);
        check("arst.data", fifo_data, 0);
        check("arst.busy", capture_busy, 0);
        check("arst.done", capture_done, 0);
        check("arst.ovf", overflow_flag, 0);
        check("arst.drop", drop_count, 0);
        check("arst.written", samples_written, 0);
        adc_valid = 0;
        #20 rst_n = 1;
        repeat (2) @(posedge clk_50M);
        run_shot("post_rst", 4, 6, 2, 80, 20, -1, -2, -1, -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
